mips_cpu_npc: RTL and testbench
===============================

MIPS_CPU_NPC -- requirements
Module: mips_cpu_npc

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'hBFC00000, the address whose delay-slot successor is computed after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port stall, input, 1: hold the current PC and all state this cycle.
REQ-005 SHALL have port pc_curr, input, 32: PC of the instruction in flight; driven by the PC register.
REQ-006 SHALL have port branch_taken, input, 1: the conditional branch at pc_curr is taken.
REQ-007 SHALL have port branch_offset, input, 16: the raw immediate of that branch.
REQ-008 SHALL have port jump, input, 1: J/JAL at pc_curr.
REQ-009 SHALL have port jump_index, input, 26: the J-type index field.
REQ-010 SHALL have port jump_reg, input, 1: JR/JALR at pc_curr.
REQ-011 SHALL have port reg_target, input, 32: the rs value for JR/JALR.
REQ-012 SHALL have port npc_out, output, 32: next PC; feeds the PC register's cpc_in.
REQ-013 SHALL have port in_delay_slot, output, 1: high while a redirect is pending, i.e. pc_curr is a delay-slot instruction.
REQ-014 SHALL have port addr_err, output, 1: sticky flag for a misaligned redirect target.

Function
REQ-015 SHALL implement a two-state FSM with states SEQ (no redirect pending) and PEND (target latched, delay slot executing).
REQ-016 SHALL, in SEQ with no redirect input, drive npc_out = pc_curr + 4, with modulo-2^32 wrap (32'hFFFFFFFC -> 32'h00000000).
REQ-017 SHALL apply redirect priority jump_reg > jump > branch_taken when more than one is asserted.
REQ-018 SHALL compute the branch target as pc_curr + 4 + (sign-extended branch_offset << 2), mod 2^32.
REQ-019 SHALL compute the jump target as {(pc_curr+4)[31:28], jump_index, 2'b00}.
REQ-020 SHALL compute the register target as reg_target unmodified; a target of 0 is legal and is how the program halts.
REQ-021 SHALL, on a redirect in SEQ without stall, drive npc_out = pc_curr + 4 (the delay slot), latch the target, and move to PEND at the clock edge.
REQ-022 SHALL, in PEND without stall, drive npc_out = latched target and return to SEQ at the clock edge.
REQ-023 SHALL ignore any redirect input while in PEND (branch in a delay slot); the first latched target wins.
REQ-024 SHALL, when stall=1, drive npc_out = pc_curr and leave state, target and addr_err unchanged; a redirect presented under stall is not latched.
REQ-025 SHALL drive in_delay_slot = 1 exactly while in PEND.
REQ-026 SHALL set addr_err when a latched target has bits [1:0] != 0; addr_err stays set until reset, and the target is still used unmodified.
REQ-027 SHALL give combinational npc_out with zero latency from its inputs and the current state; the only registered elements are state, the target and addr_err.

Reset
REQ-028 SHALL, on rst assertion at any time (including in PEND or under stall), immediately force state = SEQ, target = 0 and addr_err = 0.
REQ-029 SHALL, while rst is high, drive npc_out = RESET_VECTOR + 4 and in_delay_slot = 0.

Structure
REQ-030 SHALL take RESET_VECTOR's default, the SEQ/PEND state enum and a PC_STEP = 4 constant from the shared package mips_cpu_pkg.
REQ-031 SHALL place target arithmetic (branch/jump/register select and priority) in the combinational sub-module mips_cpu_npc_target; the FSM and registers stay in mips_cpu_npc.

Verification
REQ-032 SHALL verify sequential flow: pc_curr 32'hBFC00000, no redirect -> npc_out 32'hBFC00004, in_delay_slot 0.
REQ-033 SHALL verify a negative branch: pc_curr 32'hBFC00010, branch_taken, offset 16'hFFFE -> npc_out 32'hBFC00014; next cycle, pc_curr 32'hBFC00014 -> npc_out 32'hBFC0000C, in_delay_slot 1, then SEQ.
REQ-034 SHALL verify halt: jump_reg with reg_target 0 at pc_curr 32'hBFC00020 -> npc_out 32'hBFC00024, then 32'h00000000, addr_err 0.
REQ-035 SHALL verify J, stall and an ignored redirect: J index 26'h0000040 at 32'hBFC00000 -> latched target 32'hB0000100; two stall cycles in PEND hold npc_out = pc_curr; a branch asserted in PEND is ignored and npc_out = 32'hB0000100.
REQ-036 SHALL verify misalignment and priority: jump_reg and jump asserted together with reg_target 32'h00000102 -> target 32'h00000102 is used and addr_err rises and stays set until rst.
REQ-037 SHALL verify reset mid-operation: rst asserted asynchronously in PEND -> in_delay_slot 0 immediately and npc_out = 32'hBFC00004.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the MIPS CPU next-PC logic.
//   RESET_VECTOR_DEFAULT : boot address (kseg1 ROM)
//   PC_STEP              : sequential instruction stride in bytes
//   npc_state_e          : SEQ = no redirect pending, PEND = target latched
package mips_cpu_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;
  localparam logic [31:0] PC_STEP              = 32'd4;

  typedef enum logic {
    SEQ  = 1'b0,
    PEND = 1'b1
  } npc_state_e;

endpackage

// File: rtl/mips_cpu_npc_target.sv
// Combinational redirect-target calculation.
//   pc_curr                     : PC of the instruction in flight
//   branch_taken/branch_offset  : conditional branch and its raw immediate
//   jump/jump_index             : J/JAL and its 26-bit index
//   jump_reg/reg_target         : JR/JALR and the rs value
//   seq_pc                      : pc_curr + 4 (wraps mod 2^32)
//   redirect                    : any redirect requested
//   target                      : selected target, priority jump_reg > jump > branch
module mips_cpu_npc_target
  import mips_cpu_pkg::*;
(
  input  logic [31:0] pc_curr,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  output logic [31:0] seq_pc,
  output logic        redirect,
  output logic [31:0] target
);

  logic [31:0] branch_disp;

  always_comb begin
    seq_pc      = pc_curr + PC_STEP;
    branch_disp = {{14{branch_offset[15]}}, branch_offset, 2'b00};
    redirect    = jump_reg | jump | branch_taken;
    target      = '0;
    if (jump_reg) begin
      target = reg_target;
    end else if (jump) begin
      // Region bits come from the delay-slot address, not pc_curr.
      target = {seq_pc[31:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      target = seq_pc + branch_disp;
    end
  end

endmodule

// File: rtl/mips_cpu_npc.sv
// Next-PC generator with one branch delay slot.
//   clk, rst       : clock, asynchronous active-high reset
//   stall          : hold PC and all state this cycle
//   pc_curr        : current PC from the PC register
//   branch_*, jump*, reg_target : redirect requests for pc_curr
//   npc_out        : combinational next PC (to the PC register's cpc_in)
//   in_delay_slot  : pc_curr is the delay-slot instruction of a redirect
//   addr_err       : sticky, a latched target was not word aligned
module mips_cpu_npc
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] pc_curr,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  output logic [31:0] npc_out,
  output logic        in_delay_slot,
  output logic        addr_err
);

  npc_state_e  state_q, state_d;
  logic [31:0] target_q, target_d;
  logic        addr_err_q, addr_err_d;

  logic [31:0] seq_pc;
  logic        redirect;
  logic [31:0] new_target;

  mips_cpu_npc_target u_target (
    .pc_curr       (pc_curr),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jump_reg      (jump_reg),
    .reg_target    (reg_target),
    .seq_pc        (seq_pc),
    .redirect      (redirect),
    .target        (new_target)
  );

  // Next-state: redirects are only accepted in SEQ, so a branch sitting in a
  // delay slot never overwrites the first latched target.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    addr_err_d = addr_err_q;
    if (!stall) begin
      unique case (state_q)
        SEQ: begin
          if (redirect) begin
            state_d    = PEND;
            target_d   = new_target;
            addr_err_d = addr_err_q | (new_target[1:0] != 2'b00);
          end
        end
        PEND: begin
          state_d = SEQ;
        end
        default: state_d = SEQ;
      endcase
    end
  end

  // Outputs: reset override kept separate so rst stays out of the flop D path.
  always_comb begin
    npc_out       = seq_pc;
    in_delay_slot = (state_q == PEND);
    if (rst) begin
      npc_out       = RESET_VECTOR + PC_STEP;
      in_delay_slot = 1'b0;
    end else if (stall) begin
      npc_out = pc_curr;
    end else if (state_q == PEND) begin
      npc_out = target_q;
    end
  end

  assign addr_err = addr_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SEQ;
      target_q   <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      addr_err_q <= addr_err_d;
    end
  end

endmodule

// File: tb/tb_mips_cpu_npc.sv
module tb_mips_cpu_npc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] pc_curr = '0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_offset = '0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = '0;
  logic        jump_reg = 1'b0;
  logic [31:0] reg_target = '0;
  logic [31:0] npc_out;
  logic        in_delay_slot;
  logic        addr_err;

  mips_cpu_npc #(.RESET_VECTOR(32'hBFC00000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .pc_curr       (pc_curr),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jump_reg      (jump_reg),
    .reg_target    (reg_target),
    .npc_out       (npc_out),
    .in_delay_slot (in_delay_slot),
    .addr_err      (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic [31:0] pc;
    logic        bt;
    logic [15:0] off;
    logic        j;
    logic [25:0] idx;
    logic        jr;
    logic [31:0] rt;
    logic [31:0] e_npc;
    logic        e_ds;
    logic        e_err;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] npc;
    logic        ds;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic r, logic s, logic [31:0] pc, logic bt, logic [15:0] off,
                              logic j, logic [25:0] idx, logic jr, logic [31:0] rt,
                              logic [31:0] e_npc, logic e_ds, logic e_err);
    vec_t v;
    v.rst = r; v.stall = s; v.pc = pc; v.bt = bt; v.off = off; v.j = j; v.idx = idx;
    v.jr = jr; v.rt = rt; v.e_npc = e_npc; v.e_ds = e_ds; v.e_err = e_err;
    return v;
  endfunction

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard_empty: no expected entry at t=%0t", $time);
      n_bad++;
      return;
    end
    e = sb.pop_front();
    n_vec++;
    if (npc_out !== e.npc) begin
      $display("FAIL %s npc_out: got %h want %h", e.name, npc_out, e.npc);
      n_bad++;
    end
    if (in_delay_slot !== e.ds) begin
      $display("FAIL %s in_delay_slot: got %b want %b", e.name, in_delay_slot, e.ds);
      n_bad++;
    end
    if (addr_err !== e.err) begin
      $display("FAIL %s addr_err: got %b want %b", e.name, addr_err, e.err);
      n_bad++;
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    exp_t e;
    @(negedge clk);
    rst = v.rst; stall = v.stall; pc_curr = v.pc;
    branch_taken = v.bt; branch_offset = v.off;
    jump = v.j; jump_index = v.idx;
    jump_reg = v.jr; reg_target = v.rt;
    e.name = name; e.npc = v.e_npc; e.ds = v.e_ds; e.err = v.e_err;
    sb.push_back(e);
    #4;
    check_out();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    //             rst stall pc            bt off       j  idx          jr rt            npc           ds err
    vecs.push_back(mk(1, 0, 32'h00000000, 0, 16'h0000, 0, 26'h0000000, 0, 32'h0,        32'hBFC00004, 0, 0)); // reset
    vecs.push_back(mk(0, 0, 32'hBFC00000, 0, 16'h0000, 0, 26'h0000000, 0, 32'h0,        32'hBFC00004, 0, 0)); // seq
    vecs.push_back(mk(0, 0, 32'hBFC00010, 1, 16'hFFFE, 0, 26'h0000000, 0, 32'h0,        32'hBFC00014, 0, 0)); // neg branch
    vecs.push_back(mk(0, 0, 32'hBFC00014, 0, 16'h0000, 0, 26'h0000000, 0, 32'h0,        32'hBFC0000C, 1, 0)); // delay slot
    vecs.push_back(mk(0, 0, 32'hBFC0000C, 0, 16'h0000, 0, 26'h0000000, 0, 32'h0,        32'hBFC00010, 0, 0)); // back to seq
    vecs.push_back(mk(0, 0, 32'hFFFFFFFC, 0, 16'h0000, 0, 26'h0000000, 0, 32'h0,        32'h00000000, 0, 0)); // wrap
    vecs.push_back(mk(0, 0, 32'hBFC00020, 0, 16'h0000, 0, 26'h0000000, 1, 32'h0,        32'hBFC00024, 0, 0)); // halt jr
    vecs.push_back(mk(0, 0, 32'hBFC00024, 0, 16'h0000, 0, 26'h0000000, 0, 32'h0,        32'h00000000, 1, 0)); // halt target
    vecs.push_back(mk(0, 0, 32'hBFC00000, 0, 16'h0000, 1, 26'h0000040, 0, 32'h0,        32'hBFC00004, 0, 0)); // J
    vecs.push_back(mk(0, 1, 32'hBFC00004, 0, 16'h0000, 0, 26'h0000000, 0, 32'h0,        32'hBFC00004, 1, 0)); // stall 1
    vecs.push_back(mk(0, 1, 32'hBFC00004, 0, 16'h0000, 0, 26'h0000000, 0, 32'h0,        32'hBFC00004, 1, 0)); // stall 2
    vecs.push_back(mk(0, 0, 32'hBFC00004, 1, 16'h0010, 0, 26'h0000000, 0, 32'h0,        32'hB0000100, 1, 0)); // ignored br
    vecs.push_back(mk(0, 0, 32'hB0000100, 0, 16'h0000, 0, 26'h0000000, 0, 32'h0,        32'hB0000104, 0, 0)); // after J
    vecs.push_back(mk(0, 1, 32'h00000100, 0, 16'h0000, 0, 26'h0000000, 1, 32'h00000800, 32'h00000100, 0, 0)); // stalled jr
    vecs.push_back(mk(0, 0, 32'h00000100, 0, 16'h0000, 0, 26'h0000000, 0, 32'h0,        32'h00000104, 0, 0)); // not latched
    vecs.push_back(mk(0, 0, 32'h00000200, 0, 16'h0000, 1, 26'h3FFFFFF, 1, 32'h00000102, 32'h00000204, 0, 0)); // jr>j
    vecs.push_back(mk(0, 0, 32'h00000204, 0, 16'h0000, 0, 26'h0000000, 0, 32'h0,        32'h00000102, 1, 1)); // misaligned
    vecs.push_back(mk(0, 0, 32'h00000102, 0, 16'h0000, 0, 26'h0000000, 0, 32'h0,        32'h00000106, 0, 1)); // sticky
    vecs.push_back(mk(0, 0, 32'h00000000, 1, 16'h7FFF, 0, 26'h0000000, 0, 32'h0,        32'h00000004, 0, 1)); // max pos br
    vecs.push_back(mk(0, 0, 32'h00000004, 0, 16'h0000, 0, 26'h0000000, 0, 32'h0,        32'h00020000, 1, 1)); // max pos tgt
    vecs.push_back(mk(1, 0, 32'h00000008, 0, 16'h0000, 0, 26'h0000000, 0, 32'h0,        32'hBFC00004, 0, 0)); // rst clears
    vecs.push_back(mk(0, 0, 32'h00000010, 0, 16'h0000, 0, 26'h0000000, 0, 32'h0,        32'h00000014, 0, 0)); // post rst
    vecs.push_back(mk(0, 0, 32'h00001000, 1, 16'h0005, 1, 26'h0000010, 0, 32'h0,        32'h00001004, 0, 0)); // j>br
    vecs.push_back(mk(0, 0, 32'h00001004, 0, 16'h0000, 0, 26'h0000000, 0, 32'h0,        32'h00000040, 1, 0)); // j target
    vecs.push_back(mk(0, 0, 32'h0FFFFFFC, 0, 16'h0000, 1, 26'h0000001, 0, 32'h0,        32'h10000000, 0, 0)); // region cross
    vecs.push_back(mk(0, 0, 32'h10000000, 0, 16'h0000, 0, 26'h0000000, 0, 32'h0,        32'h10000004, 1, 0)); // region tgt

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset while a target is pending.
    apply(mk(0, 0, 32'hBFC00000, 0, 16'h0000, 1, 26'h0000040, 0, 32'h0, 32'hBFC00004, 0, 0), "ar_j");
    @(posedge clk);
    #2;
    e.name = "ar_pend"; e.npc = 32'hB0000100; e.ds = 1'b1; e.err = 1'b0;
    sb.push_back(e);
    pc_curr = 32'hBFC00004; jump = 1'b0; jump_index = '0;
    #0 check_out();
    rst = 1'b1;
    e.name = "ar_async"; e.npc = 32'hBFC00004; e.ds = 1'b0; e.err = 1'b0;
    sb.push_back(e);
    #1 check_out();
    apply(mk(0, 0, 32'hBFC00004, 0, 16'h0000, 0, 26'h0000000, 0, 32'h0, 32'hBFC00008, 0, 0), "ar_after");

    if (sb.size() != 0) begin
      $display("FAIL scoreboard_leftover: %0d entries remain, want 0", sb.size());
      n_bad++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
